// File: rtl/serial_pattern_ctrl.sv
// serial_pattern_ctrl
//   Accepts bytes over a valid/ready handshake and shifts them MSB-first,
//   one bit per clock, through a programmable 4-bit overlapping pattern
//   matcher. Counts matches (saturating) and raises a sticky interrupt when
//   the count reaches a programmable threshold.
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous, active-high reset
//   cfg_we       config write strobe (honoured only while idle)
//   cfg_seq      pattern, bit 3 is matched first in time
//   cfg_thresh   match count that raises irq (0 disables irq)
//   in_valid     producer has a byte
//   in_data      byte, shifted MSB first
//   in_ready     byte accepted this cycle (high exactly while idle)
//   busy         high while shifting
//   match_pulse  one-cycle pulse per completed match
//   match_cnt    matches since reset/config, saturating
//   irq          sticky threshold interrupt
//   irq_clr      clears irq (a same-edge set wins)
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | ready for a byte or a config write
// SHIFT | feeding the held byte into the window, 1 bit/clk

module serial_pattern_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [3:0]       cfg_seq,
  input  logic [CNT_W-1:0] cfg_thresh,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             busy,
  output logic             match_pulse,
  output logic [CNT_W-1:0] match_cnt,
  output logic             irq,
  input  logic             irq_clr
);

  localparam int BC_W = $clog2(WIDTH);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] sr;
  logic [BC_W-1:0]  bit_cnt;
  logic [3:0]       win;
  logic [2:0]       fill;
  logic [3:0]       pat;
  logic [CNT_W-1:0] thr;

  logic             load;
  logic             cfg_load;
  logic             shift_en;

  logic [3:0]       win_next;
  logic [2:0]       fill_next;
  logic [CNT_W-1:0] cnt_plus;
  logic             hit;
  logic             cnt_inc;
  logic             irq_set;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // next state and handshake outputs
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    load       = 1'b0;
    cfg_load   = 1'b0;
    shift_en   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load       = 1'b1;
          state_next = SHIFT;
        end else if (cfg_we) begin
          cfg_load = 1'b1;
        end
      end
      SHIFT: begin
        busy     = 1'b1;
        shift_en = 1'b1;
        if (bit_cnt == '0) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The match decision looks at the window as it will be after this edge,
  // so the pulse and the count land on the edge that shifts in the last bit.
  always_comb begin
    win_next  = {win[2:0], sr[WIDTH-1]};
    fill_next = (fill == 3'd4) ? 3'd4 : fill + 3'd1;
    cnt_plus  = match_cnt + CNT_W'(1);
    hit       = shift_en && (fill_next == 3'd4) && (win_next == pat);
    cnt_inc   = hit && (match_cnt != CNT_MAX);
    // only a real increment can reach thr, so a saturated counter never re-arms irq
    irq_set   = cnt_inc && (thr != '0) && (cnt_plus == thr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr          <= '0;
      bit_cnt     <= '0;
      win         <= 4'b0000;
      fill        <= 3'd0;
      pat         <= 4'b0110;
      thr         <= '0;
      match_cnt   <= '0;
      match_pulse <= 1'b0;
      irq         <= 1'b0;
    end else begin
      match_pulse <= hit;

      if (load) begin
        sr      <= in_data;
        bit_cnt <= BC_LAST;
      end else if (cfg_load) begin
        pat  <= cfg_seq;
        thr  <= cfg_thresh;
        win  <= 4'b0000;
        fill <= 3'd0;
      end else if (shift_en) begin
        win     <= win_next;
        sr      <= sr << 1;
        fill    <= fill_next;
        bit_cnt <= bit_cnt - BC_W'(1);
      end

      if (cfg_load)     match_cnt <= '0;
      else if (cnt_inc) match_cnt <= cnt_plus;

      if (cfg_load)     irq <= 1'b0;
      else if (irq_set) irq <= 1'b1;
      else if (irq_clr) irq <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_pattern_ctrl.sv
module tb_serial_pattern_ctrl;

  localparam int WIDTH   = 8;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_we;
  logic [3:0]       cfg_seq;
  logic [CNT_W-1:0] cfg_thresh;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             busy;
  logic             match_pulse;
  logic [CNT_W-1:0] match_cnt;
  logic             irq;
  logic             irq_clr;

  serial_pattern_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_seq(cfg_seq),
    .cfg_thresh(cfg_thresh), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .busy(busy), .match_pulse(match_pulse),
    .match_cnt(match_cnt), .irq(irq), .irq_clr(irq_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit pulse;
    int cnt;
    bit irq;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  bit   prev_busy   = 1'b0;

  // reference model: bit history, pattern, threshold, count, irq
  int       hist[$];
  bit [3:0] m_pat;
  int       m_thr;
  int       m_cnt;
  bit       m_irq;

  function automatic void check(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void model_cfg(bit [3:0] seq, int thr);
    m_pat = seq;
    m_thr = thr;
    m_cnt = 0;
    m_irq = 1'b0;
    hist.delete();
  endfunction

  function automatic exp_t model_bit(bit b, bit clr);
    exp_t r;
    int   v;
    bit   hit, set;
    hist.push_back(int'(b));
    if (hist.size() > 4) void'(hist.pop_front());
    hit = 1'b0;
    set = 1'b0;
    if (hist.size() == 4) begin
      v   = hist[0] * 8 + hist[1] * 4 + hist[2] * 2 + hist[3];
      hit = (v == int'(m_pat));
    end
    if (hit && m_cnt < CNT_MAX) begin
      m_cnt++;
      if (m_thr != 0 && m_cnt == m_thr) set = 1'b1;
    end
    if (set)      m_irq = 1'b1;
    else if (clr) m_irq = 1'b0;
    r.pulse = hit;
    r.cnt   = m_cnt;
    r.irq   = m_irq;
    return r;
  endfunction

  // monitor: after every edge that was a shift edge, pop and compare
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_busy = 1'b0;
        continue;
      end
      check("ready_vs_busy", int'(in_ready), int'(!busy));
      if (prev_busy) begin
        if (exp_q.size() == 0) begin
          check("scoreboard_underflow", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("match_pulse", int'(match_pulse), int'(e.pulse));
          check("match_cnt", int'(match_cnt), e.cnt);
          check("irq", int'(irq), int'(e.irq));
        end
      end else begin
        check("idle_pulse", int'(match_pulse), 0);
      end
      prev_busy = busy;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_ready();
    int guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) check("ready_timeout", 0, 1);
  endtask

  // clr_mask[k] asserts irq_clr before shift edge k+1; noise drives cfg_we
  // during acceptance and the whole shift, which must be ignored
  task automatic send(input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] clr_mask,
                      input bit noise);
    wait_ready();
    for (int k = 0; k < WIDTH; k++)
      exp_q.push_back(model_bit(d[WIDTH-1-k], clr_mask[k]));
    in_valid = 1'b1;
    in_data  = d;
    if (noise) begin
      cfg_we     = 1'b1;
      cfg_seq    = 4'($urandom);
      cfg_thresh = CNT_W'($urandom);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = WIDTH'($urandom);
    for (int k = 0; k < WIDTH; k++) begin
      irq_clr = clr_mask[k];
      cfg_we  = noise;
      if (noise) cfg_seq = 4'($urandom);
      @(posedge clk); #1;
    end
    irq_clr = 1'b0;
    cfg_we  = 1'b0;
  endtask

  task automatic cfg(input logic [3:0] seq, input int thr);
    wait_ready();
    cfg_we     = 1'b1;
    cfg_seq    = seq;
    cfg_thresh = CNT_W'(thr);
    @(posedge clk); #1;
    cfg_we = 1'b0;
    model_cfg(seq, thr);
    check("cfg_cnt", int'(match_cnt), 0);
    check("cfg_irq", int'(irq), 0);
  endtask

  task automatic clear_irq();
    irq_clr = 1'b1;
    @(posedge clk); #1;
    irq_clr = 1'b0;
    m_irq = 1'b0;
    check("irq_clr_idle", int'(irq), 0);
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_ready"}, int'(in_ready), 1);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_cnt"}, int'(match_cnt), 0);
    check({tag, "_pulse"}, int'(match_pulse), 0);
    check({tag, "_irq"}, int'(irq), 0);
  endtask

  initial begin
    rst        = 1'b1;
    cfg_we     = 1'b0;
    cfg_seq    = 4'h0;
    cfg_thresh = '0;
    in_valid   = 1'b0;
    in_data    = '0;
    irq_clr    = 1'b0;
    model_cfg(4'b0110, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_outputs("reset");

    // default pattern 0110: single match, double match, cross-boundary match
    send(8'h56, 8'h00, 1'b0);
    check("cnt_after_56", int'(match_cnt), 1);
    send(8'h66, 8'h00, 1'b0);
    send(8'h03, 8'h00, 1'b0);
    send(8'h00, 8'h00, 1'b0);

    // 1111 on all-ones: consecutive pulses, irq at the 3rd
    cfg(4'b1111, 3);
    send(8'hFF, 8'h00, 1'b0);
    check("irq_at_thr", int'(irq), 1);
    clear_irq();
    send(8'hFF, 8'h01, 1'b0);
    // re-arm; clr coincides with the 3rd match (set wins), then clears next edge
    cfg(4'b1111, 3);
    send(8'hFF, 8'b0110_0000, 1'b0);
    check("irq_after_clr", int'(irq), 0);

    // cfg_we during acceptance and shift is ignored
    cfg(4'b0110, 0);
    send(8'h56, 8'h00, 1'b1);
    send(8'h66, 8'h00, 1'b1);
    check("noise_cnt", int'(match_cnt), 3);

    // saturation with irq disabled
    cfg(4'b1111, 0);
    for (int i = 0; i < 38; i++) send(8'hFF, 8'h00, 1'b0);
    check("sat_cnt", int'(match_cnt), CNT_MAX);
    check("sat_irq", int'(irq), 0);

    // threshold at the saturation value: set once, never re-set
    cfg(4'b1111, CNT_MAX);
    for (int i = 0; i < 33; i++) send(8'hFF, 8'h00, 1'b0);
    check("thr_max_irq", int'(irq), 1);
    clear_irq();
    send(8'hFF, 8'h00, 1'b0);
    send(8'hFF, 8'h00, 1'b0);
    check("sat_no_reset_irq", int'(irq), 0);

    // randomized traffic
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 7) == 0) cfg(4'($urandom), int'($urandom_range(0, 6)));
      send(WIDTH'($urandom),
           ($urandom_range(0, 3) == 0) ? WIDTH'($urandom) : WIDTH'(0),
           ($urandom_range(0, 4) == 0));
    end

    // asynchronous reset in the middle of a byte
    cfg(4'b0110, 2);
    send(8'h66, 8'h00, 1'b0);
    wait_ready();
    for (int k = 0; k < WIDTH; k++) exp_q.push_back(model_bit(k[0], 1'b0));
    in_valid = 1'b1;
    in_data  = 8'h55;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    prev_busy = 1'b0;
    model_cfg(4'b0110, 0);
    #1;
    check_reset_outputs("async_rst");
    #1 rst = 1'b0;
    send(8'h56, 8'h00, 1'b0);
    check("post_rst_cnt", int'(match_cnt), 1);

    repeat (3) @(posedge clk);
    #1;
    check("queue_drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
